// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [0:0] {
      ARB,
      EXT_ACK
   } arb_state_t;

   localparam int DEFAULT_ADDR_WIDTH = 32;
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_MAX_WAIT   = 4;
   // Wide enough for the largest legal MAX_WAIT of 15.
   localparam int WAIT_CNT_WIDTH     = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the ext port has been denied.
module arb_starve_counter
   import dmem_arb_pkg::*;
#(
   parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      inc,
   input  logic                      clr,
   input  logic                      hold,
   output logic [WAIT_CNT_WIDTH-1:0] count,
   output logic                      at_max
);

   localparam logic [WAIT_CNT_WIDTH-1:0] MAX_CNT = WAIT_CNT_WIDTH'(MAX_WAIT);
   localparam logic [WAIT_CNT_WIDTH-1:0] ONE     = WAIT_CNT_WIDTH'(1);

   assign at_max = (count >= MAX_CNT);

   // Hold wins so the count is frozen during the ack cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (hold) begin
         count <= count;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the data memory: CPU MEM stage has priority, ext master is starvation-protected.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int MAX_WAIT   = DEFAULT_MAX_WAIT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [ADDR_WIDTH-1:0] ext_addr,
   input  logic [DATA_WIDTH-1:0] ext_wdata,
   output logic [DATA_WIDTH-1:0] ext_rdata,
   output logic                  ext_ack,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   arb_state_t                state;
   arb_state_t                next_state;
   logic                      ext_grant;
   logic                      cpu_grant;
   logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
   logic                      at_max;
   logic                      in_ack;

   assign in_ack  = (state == EXT_ACK);
   assign ext_ack = in_ack;

   arb_starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_counter (
      .clock  (clock),
      .reset  (reset),
      .inc    (ext_req & ~ext_grant),
      .clr    (ext_grant | ~ext_req),
      .hold   (in_ack),
      .count  (wait_cnt),
      .at_max (at_max)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ARB;
      end else begin
         state <= next_state;
      end
   end

   // Read data is captured at the grant edge and presented alongside ext_ack.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ext_rdata <= '0;
      end else if (ext_grant && !ext_we) begin
         ext_rdata <= mem_rdata;
      end
   end

   // In EXT_ACK the ext request is still held high, so it must be ignored to avoid a reissue.
   always_comb begin
      ext_grant  = 1'b0;
      next_state = state;
      case (state)
         ARB: begin
            ext_grant = ext_req & (~cpu_req | at_max);
            if (ext_grant) begin
               next_state = EXT_ACK;
            end
         end
         EXT_ACK: next_state = ARB;
         default: next_state = ARB;
      endcase
      cpu_grant = cpu_req & ~ext_grant;
      cpu_stall = cpu_req & ~cpu_grant;
      cpu_rdata = cpu_grant ? mem_rdata : '0;
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (ext_grant) begin
         mem_addr  = ext_addr;
         mem_wdata = ext_wdata;
         mem_we    = ext_we;
         mem_re    = ~ext_we;
      end else if (cpu_grant) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we;
         mem_re    = ~cpu_we;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (default MAX_WAIT plus a MAX_WAIT=1 instance) with a small memory model.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, ext_req, ext_we;
   logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
   logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_stall, ext_ack, mem_we, mem_re;

   logic        c2_req, e2_req;
   logic [31:0] c2_rdata, e2_rdata, m2_addr, m2_wdata;
   logic        c2_stall, e2_ack, m2_we, m2_re;

   logic [31:0] mem [0:63];
   logic [63:0] written = '0;
   int          ext_wr_count = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clock = ~clock;

   dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_rdata(ext_rdata), .ext_ack(ext_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
   );

   dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(1)) dut2 (
      .clock(clock), .reset(reset),
      .cpu_req(c2_req), .cpu_we(1'b0), .cpu_addr(32'h40), .cpu_wdata(32'h0),
      .cpu_rdata(c2_rdata), .cpu_stall(c2_stall),
      .ext_req(e2_req), .ext_we(1'b0), .ext_addr(32'h44), .ext_wdata(32'h0),
      .ext_rdata(e2_rdata), .ext_ack(e2_ack),
      .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_we(m2_we), .mem_re(m2_re),
      .mem_rdata(32'h0)
   );

   // Unwritten words read back as 0xA000_00<word index>.
   assign mem_rdata = !mem_re ? 32'h0 :
                      written[mem_addr[7:2]] ? mem[mem_addr[7:2]] :
                      (32'hA000_0000 | {26'h0, mem_addr[7:2]});

   always @(posedge clock) begin
      if (mem_we) begin
         mem[mem_addr[7:2]]     <= mem_wdata;
         written[mem_addr[7:2]] <= 1'b1;
         if (mem_addr == 32'h30) ext_wr_count <= ext_wr_count + 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_stimulus(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                                 input logic [31:0] c_wdata, input logic e_req, input logic e_we,
                                 input logic [31:0] e_addr, input logic [31:0] e_wdata);
      cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
      ext_req = e_req; ext_we = e_we; ext_addr = e_addr; ext_wdata = e_wdata;
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [5:0]  exp_stall2;
      logic [5:0]  exp_ack2;
      logic [5:0]  exp_ext2;
      exp_stall2 = 6'b010010;
      exp_ack2   = 6'b100100;
      exp_ext2   = 6'b010010;
      reset  = 1'b0;
      c2_req = 1'b0;
      e2_req = 1'b0;

      // Reset held with random traffic (loads only, so the model memory stays intact).
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'($urandom), 1'b0, $urandom & 32'hFC, $urandom,
                        1'($urandom), 1'b0, $urandom & 32'hFC, $urandom);
         tick();
         check_output("rst_ext_ack", 32'(ext_ack), 32'h0);
         check_output("rst_ext_rdata", ext_rdata, 32'h0);
      end
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
      check_output("rst_cpu_stall", 32'(cpu_stall), 32'h0);
      check_output("rst_state", 32'(dut.state), 32'(ARB));
      tick();
      reset = 1'b1;

      // Plain cpu load.
      apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_output("cpu_load_stall", 32'(cpu_stall), 32'h0);
      check_output("cpu_load_rdata", cpu_rdata, 32'hA000_0004);
      tick();

      // Uncontested ext write, ack one cycle later, then cpu reads it back.
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
      check_output("ext_wr_mem_we", 32'(mem_we), 32'h1);
      check_output("ext_wr_mem_addr", mem_addr, 32'h20);
      check_output("ext_wr_no_ack_c0", 32'(ext_ack), 32'h0);
      tick();
      check_output("ext_wr_ack_c1", 32'(ext_ack), 32'h1);
      check_output("ext_wr_no_reissue", 32'(mem_we), 32'h0);
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_output("readback_0x20", cpu_rdata, 32'hDEAD_BEEF);
      check_output("readback_ack_low", 32'(ext_ack), 32'h0);
      tick();

      // Contention: cpu wins four cycles, then ext is forced through.
      apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      for (int i = 0; i < 4; i++) begin
         check_output("contend_wait_cnt", 32'(dut.wait_cnt), 32'(i));
         check_output("contend_cpu_stall", 32'(cpu_stall), 32'h0);
         check_output("contend_cpu_rdata", cpu_rdata, 32'hA000_0004);
         tick();
      end
      check_output("forced_wait_cnt", 32'(dut.wait_cnt), 32'h4);
      check_output("forced_cpu_stall", 32'(cpu_stall), 32'h1);
      check_output("forced_mem_addr", mem_addr, 32'h20);
      check_output("forced_cpu_rdata", cpu_rdata, 32'h0);
      tick();
      check_output("forced_ack", 32'(ext_ack), 32'h1);
      check_output("forced_ext_rdata", ext_rdata, 32'hDEAD_BEEF);
      check_output("forced_wait_clr", 32'(dut.wait_cnt), 32'h0);
      check_output("ack_cycle_cpu_stall", 32'(cpu_stall), 32'h0);
      apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Ext write held through the ack cycle while cpu requests: exactly one write.
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h30, 32'h1234_5678);
      check_output("held_wr_mem_we", 32'(mem_we), 32'h1);
      tick();
      apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h30, 32'h1234_5678);
      check_output("held_ack", 32'(ext_ack), 32'h1);
      check_output("held_cpu_stall", 32'(cpu_stall), 32'h0);
      check_output("held_mem_we", 32'(mem_we), 32'h0);
      check_output("held_mem_addr", mem_addr, 32'h10);
      tick();
      apply_stimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_output("held_wr_count", 32'(ext_wr_count), 32'h1);
      check_output("held_readback", cpu_rdata, 32'h1234_5678);
      tick();

      // Reset in the cycle after an ext grant drops the pending ack.
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
      tick();
      check_output("pre_rst_ack", 32'(ext_ack), 32'h1);
      reset = 1'b0;
      #1;
      check_output("mid_rst_ack", 32'(ext_ack), 32'h0);
      check_output("mid_rst_rdata", ext_rdata, 32'h0);
      check_output("mid_rst_state", 32'(dut.state), 32'(ARB));
      check_output("mid_rst_wait_cnt", 32'(dut.wait_cnt), 32'h0);
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      reset = 1'b1;
      tick();
      check_output("post_rst_no_ack", 32'(ext_ack), 32'h0);
      apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_output("post_rst_mem_kept", cpu_rdata, 32'hDEAD_BEEF);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

      // MAX_WAIT=1 with both ports requesting continuously.
      c2_req = 1'b1;
      e2_req = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         check_output("mw1_cpu_stall", 32'(c2_stall), 32'(exp_stall2[i]));
         check_output("mw1_ext_ack", 32'(e2_ack), 32'(exp_ack2[i]));
         check_output("mw1_mem_addr", m2_addr, exp_ext2[i] ? 32'h44 : 32'h40);
         tick();
      end
      c2_req = 1'b0;
      e2_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
